// File: rtl/duck_hit_compositor.sv
// Composites sky, ground and duck sprite into registered RGB, and runs the
// trigger -> black frame -> white-box frame -> verdict hit-detection sequence.
module duck_hit_compositor #(
  parameter logic [9:0]  GROUND_Y   = 10'd400,
  parameter logic [23:0] SKY_RGB    = 24'h3CBCFC,
  parameter logic [23:0] GROUND_RGB = 24'h80D010,
  parameter logic [1:0]  SHOTS_INIT = 2'd3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank_n,
  input  logic        is_duck,
  input  logic [15:0] duck_addr,
  output logic [15:0] rom_addr,
  input  logic [3:0]  rom_index,
  output logic [3:0]  pal_index,
  input  logic [23:0] pal_rgb,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  input  logic        trigger,
  input  logic        reload,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        blank_n_out,
  output logic        hit,
  output logic        miss,
  output logic [1:0]  shots_left,
  output logic        busy
);

  typedef enum logic [2:0] {PLAY, ARMED, BLACK, WHITE, RESOLVE} state_t;

  typedef struct packed {
    logic [9:0] y;
    logic       duck;
    logic       blank;
  } side_t;

  state_t           state;
  side_t            side0;
  side_t [2:1]      side_pipe;
  logic [3:0]       idx_q;
  logic [23:0]      rgb_q;
  logic [23:0]      rgb_next;
  logic             frame_q1, frame_q2, trigger_q;
  logic             fe, fire, aim_match, hit_flag;

  // Both ROM addresses are pure pass-throughs; the ROMs supply the latency.
  assign rom_addr  = duck_addr;
  assign pal_index = rom_index;
  assign side0     = {DrawY, is_duck, blank_n};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      side_pipe   <= '0;
      idx_q       <= '0;
      rgb_q       <= '0;
      blank_n_out <= 1'b0;
    end else begin
      side_pipe[1] <= side0;
      side_pipe[2] <= side_pipe[1];
      idx_q        <= rom_index;
      rgb_q        <= rgb_next;
      blank_n_out  <= side_pipe[2].blank;
    end
  end

  // Palette index 0 is transparent and falls through to the background.
  always_comb begin
    rgb_next = (side_pipe[2].y < GROUND_Y) ? SKY_RGB : GROUND_RGB;
    if (!side_pipe[2].blank)
      rgb_next = '0;
    else if (state == BLACK)
      rgb_next = '0;
    else if (state == WHITE)
      rgb_next = side_pipe[2].duck ? 24'hFFFFFF : 24'h000000;
    else if (side_pipe[2].duck && (idx_q != 4'd0))
      rgb_next = pal_rgb;
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q1  <= 1'b0;
      frame_q2  <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      frame_q1  <= frame_clk;
      frame_q2  <= frame_q1;
      trigger_q <= trigger;
    end
  end

  assign fe        = frame_q1 & ~frame_q2;
  assign fire      = trigger & ~trigger_q;
  assign aim_match = is_duck && blank_n && (DrawX == aim_x) && (DrawY == aim_y);

  // hit/miss are loaded on entry to RESOLVE so they are high only in that state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= PLAY;
      shots_left <= SHOTS_INIT;
      hit_flag   <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        PLAY:    if (fire && (shots_left != 2'd0)) state <= ARMED;
        ARMED:   if (fe) begin
                   state    <= BLACK;
                   hit_flag <= 1'b0;
                 end
        BLACK:   if (fe) state <= WHITE;
        WHITE: begin
          if (aim_match) hit_flag <= 1'b1;
          if (fe) begin
            state <= RESOLVE;
            hit   <= hit_flag | aim_match;
            miss  <= ~(hit_flag | aim_match);
          end
        end
        RESOLVE: state <= PLAY;
        default: state <= PLAY;
      endcase
      if (reload)
        shots_left <= SHOTS_INIT;
      else if ((state == PLAY) && fire && (shots_left != 2'd0))
        shots_left <= shots_left - 2'd1;
    end
  end

  assign busy = (state != PLAY);

endmodule

// File: tb/tb_duck_hit_compositor.sv
// Bench for duck_hit_compositor: ROM models, pixel scoreboard, table vectors
// and hand-written shot sequences.
module tb_duck_hit_compositor;

  logic        Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, aim_x = '0, aim_y = '0;
  logic        blank_n = 1'b0, is_duck = 1'b0, trigger = 1'b0, reload = 1'b0;
  logic [15:0] duck_addr = '0;
  logic [15:0] rom_addr;
  logic [3:0]  rom_index = '0;
  logic [3:0]  pal_index;
  logic [23:0] pal_rgb = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        blank_n_out, hit, miss, busy;
  logic [1:0]  shots_left;

  duck_hit_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n(blank_n), .is_duck(is_duck), .duck_addr(duck_addr), .rom_addr(rom_addr),
    .rom_index(rom_index), .pal_index(pal_index), .pal_rgb(pal_rgb), .aim_x(aim_x),
    .aim_y(aim_y), .trigger(trigger), .reload(reload), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .blank_n_out(blank_n_out), .hit(hit), .miss(miss),
    .shots_left(shots_left), .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] pal_of(input logic [3:0] i);
    return (i == 4'd5) ? 24'h123456 : {i, 4'h1, 16'hC0DE};
  endfunction

  // 1-Clk synchronous sprite and palette ROMs
  always @(posedge Clk) begin
    rom_index <= rom_addr[3:0];
    pal_rgb   <= pal_of(pal_index);
  end

  typedef struct {int cyc; logic [23:0] rgb; logic blank;} exp_t;
  typedef struct {logic [9:0] y; logic duck; logic [15:0] addr; logic blank;
                  logic [23:0] rgb; logic bo;} vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int cyc = 0, checks = 0, failures = 0;
  int hit_cyc = 0, miss_cyc = 0, both_cyc = 0, h0 = 0, m0 = 0;
  int px[8] = '{330, 320, 340, 100, 500, 10, 351, 352};
  int py[8] = '{250, 240, 260, 100, 420, 10, 271, 250};

  always @(negedge Clk) begin
    if (hit === 1'b1) hit_cyc <= hit_cyc + 1;
    if (miss === 1'b1) miss_cyc <= miss_cyc + 1;
    if (hit === 1'b1 && miss === 1'b1) both_cyc <= both_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // phase: 0 normal drawing, 1 black frame, 2 white-box frame
  function automatic logic [23:0] model(input int phase, input logic blank,
                                        input logic duck, input logic [3:0] idx,
                                        input logic [9:0] y);
    if (!blank) return 24'h0;
    if (phase == 1) return 24'h0;
    if (phase == 2) return duck ? 24'hFFFFFF : 24'h0;
    if (duck && idx != 4'd0) return pal_of(idx);
    return (y < 10'd400) ? 24'h3CBCFC : 24'h80D010;
  endfunction

  task automatic pix_raw(input logic [9:0] x, input logic [9:0] y, input logic duck,
                         input logic [15:0] addr, input logic blank,
                         input logic [23:0] er, input logic eb);
    exp_t e;
    @(negedge Clk);
    cyc++;
    if (sb.size() > 0 && sb[0].cyc + 3 == cyc) begin
      e = sb.pop_front();
      chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e.rgb});
      chk("blank_n_out", 32'(blank_n_out), 32'(e.blank));
    end
    DrawX = x; DrawY = y; is_duck = duck; duck_addr = addr; blank_n = blank;
    sb.push_back('{cyc, er, eb});
  endtask

  // Duck box spans x 320..351, y 240..271.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic blank, input int phase);
    logic [9:0] dx, dy;
    logic duck;
    logic [15:0] addr;
    dx = x - 10'd320;
    dy = y - 10'd240;
    duck = (x >= 10'd320) && (x < 10'd352) && (y >= 10'd240) && (y < 10'd272);
    addr = duck ? {dy[7:0], dx[7:0]} : {6'h0, x};
    pix_raw(x, y, duck, addr, blank, model(phase, blank, duck, addr[3:0], y), blank);
  endtask

  task automatic idle(input int n);
    repeat (n) pix(10'd0, 10'd0, 1'b0, 0);
  endtask

  task automatic burst(input int phase);
    for (int i = 0; i < 8; i++) pix(10'(px[i]), 10'(py[i]), 1'b1, phase);
  endtask

  task automatic frame_tick();
    idle(2);
    frame_clk = 1'b1;
    idle(3);
    frame_clk = 1'b0;
    idle(3);
  endtask

  task automatic shoot(input logic [9:0] ax, input logic [9:0] ay, input bit hold,
                       input bit exp_hit, input bit fe_same, input logic [1:0] shots_exp);
    aim_x = ax; aim_y = ay;
    if (fe_same) begin
      frame_clk = 1'b1;
      idle(1);
    end
    trigger = 1'b1;
    idle(1);
    chk("busy_armed", 32'(busy), 32'd1);
    chk("shots_dec", 32'(shots_left), 32'(shots_exp));
    if (fe_same) frame_clk = 1'b0;
    if (!hold) trigger = 1'b0;
    burst(0);
    frame_tick();
    burst(1);
    if (!hold) begin
      trigger = 1'b1; idle(1); trigger = 1'b0; idle(1);
    end
    chk("shots_fire_in_black", 32'(shots_left), 32'(shots_exp));
    chk("busy_black", 32'(busy), 32'd1);
    frame_tick();
    burst(2);
    h0 = hit_cyc; m0 = miss_cyc;
    frame_tick();
    idle(2);
    chk("hit_pulse_cycles", 32'(hit_cyc - h0), exp_hit ? 32'd1 : 32'd0);
    chk("miss_pulse_cycles", 32'(miss_cyc - m0), exp_hit ? 32'd0 : 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("shots_done", 32'(shots_left), 32'(shots_exp));
    if (hold) begin
      idle(3);
      chk("held_trigger_one_fire", 32'(shots_left), 32'(shots_exp));
      chk("held_trigger_busy", 32'(busy), 32'd0);
      trigger = 1'b0;
      idle(1);
    end
  endtask

  initial begin
    vt[0] = '{10'd100, 1'b1, 16'h0005, 1'b1, 24'h123456, 1'b1};
    vt[1] = '{10'd100, 1'b1, 16'h0000, 1'b1, 24'h3CBCFC, 1'b1};
    vt[2] = '{10'd400, 1'b1, 16'h0000, 1'b1, 24'h80D010, 1'b1};
    vt[3] = '{10'd399, 1'b0, 16'h0005, 1'b1, 24'h3CBCFC, 1'b1};
    vt[4] = '{10'd400, 1'b1, 16'h0005, 1'b1, 24'h123456, 1'b1};
    vt[5] = '{10'd100, 1'b1, 16'h0005, 1'b0, 24'h000000, 1'b0};
    vt[6] = '{10'd479, 1'b0, 16'h0000, 1'b1, 24'h80D010, 1'b1};
    vt[7] = '{10'd100, 1'b1, 16'h0003, 1'b1, 24'h31C0DE, 1'b1};
    vt[8] = '{10'd0,   1'b0, 16'h0000, 1'b0, 24'h000000, 1'b0};
    vt[9] = '{10'd100, 1'b1, 16'hFFF0, 1'b1, 24'h3CBCFC, 1'b1};

    Reset = 1'b1;
    idle(4);
    chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_blank_out", 32'(blank_n_out), 32'd0);
    chk("rst_hit_miss", {30'h0, hit, miss}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shots", 32'(shots_left), 32'd3);
    Reset = 1'b0;
    idle(1);

    for (int i = 0; i < 10; i++)
      pix_raw(10'd0, vt[i].y, vt[i].duck, vt[i].addr, vt[i].blank, vt[i].rgb, vt[i].bo);
    idle(4);

    shoot(10'd330, 10'd250, 1'b0, 1'b1, 1'b0, 2'd2);
    shoot(10'd10,  10'd10,  1'b1, 1'b0, 1'b1, 2'd1);
    shoot(10'd10,  10'd10,  1'b0, 1'b0, 1'b0, 2'd0);

    trigger = 1'b1; idle(1);
    chk("empty_fire_busy", 32'(busy), 32'd0);
    chk("empty_fire_shots", 32'(shots_left), 32'd0);
    trigger = 1'b0; idle(1);

    reload = 1'b1; idle(1); reload = 1'b0;
    chk("reload_shots", 32'(shots_left), 32'd3);

    aim_x = 10'd330; aim_y = 10'd250;
    trigger = 1'b1; reload = 1'b1; idle(1);
    reload = 1'b0; trigger = 1'b0;
    chk("reload_wins_shots", 32'(shots_left), 32'd3);
    chk("reload_fire_armed", 32'(busy), 32'd1);
    burst(0);
    frame_tick();
    burst(1);
    frame_tick();
    burst(2);
    repeat (3) pix(10'd330, 10'd250, 1'b1, 2);
    h0 = hit_cyc; m0 = miss_cyc;
    Reset = 1'b1;
    sb.delete();
    idle(1);
    Reset = 1'b0;
    chk("midrst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_shots", 32'(shots_left), 32'd3);
    idle(2);
    burst(0);
    repeat (3) frame_tick();
    burst(0);
    chk("midrst_no_hit", 32'(hit_cyc), 32'(h0));
    chk("midrst_no_miss", 32'(miss_cyc), 32'(m0));

    idle(4);
    chk("hit_miss_overlap", 32'(both_cyc), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/duck_hit_compositor.md
# duck_hit_compositor

Pixel-pipeline stage directly downstream of the duck sprite block. Consumes the per-pixel `is_duck` flag and `duck_addr`, fetches sprite and palette data from external synchronous ROMs, and composites sky, ground and duck into registered 24-bit RGB for the VGA output. Also runs the trigger/flash hit-detection sequence: one black frame, then one frame with the duck drawn as a white box, then a hit or miss verdict. Tracks remaining shots.

## Interface
- `GROUND_Y`, 10'd400: first DrawY row drawn as ground.
- `SKY_RGB`, 24'h3CBCFC: background colour above `GROUND_Y`.
- `GROUND_RGB`, 24'h80D010: background colour at or below `GROUND_Y`.
- `SHOTS_INIT`, 2'd3: shots loaded on reset and on `reload`.

Ports:
- `Clk` in 1: 50 MHz clock. This is the only clock.
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: frame tick, about 60 Hz, synchronous to `Clk`.
- `DrawX`, `DrawY` in 10 each: current pixel coordinates.
- `blank_n` in 1: 1 means active video.
- `is_duck` in 1: current pixel lies inside the duck box.
- `duck_addr` in 16: sprite ROM address for the current pixel.
- `rom_addr` out 16: sprite ROM read address.
- `rom_index` in 4: palette index, valid 1 Clk after `rom_addr`.
- `pal_index` out 4: palette ROM read address.
- `pal_rgb` in 24: palette colour, valid 1 Clk after `pal_index`.
- `aim_x`, `aim_y` in 10 each: crosshair position.
- `trigger` in 1: fire request, level signal.
- `reload` in 1: single-cycle pulse that restores the shot count.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: registered pixel colour.
- `blank_n_out` out 1: `blank_n` delayed to align with the RGB outputs.
- `hit`, `miss` out 1 each: single-Clk verdict pulses.
- `shots_left` out 2: remaining shots.
- `busy` out 1: 1 in any state other than PLAY.

## Operation
- **Pipeline stage 0 (combinational):** `rom_addr = duck_addr`. `DrawY`, `is_duck` and `blank_n` enter a 2-deep sideband delay line.
- **Stage 1:** `pal_index = rom_index`, combinational pass-through. The sideband advances one stage.
- **Stage 2:** `pal_rgb` arrives. The output register loads the mux result below, evaluated in priority order.
  1. Delayed `blank_n` = 0: RGB = 0.
  2. State BLACK: RGB = 0.
  3. State WHITE: RGB = 24'hFFFFFF if delayed `is_duck`, else 0.
  4. Delayed `is_duck` = 1 and `rom_index` (as registered at stage 1) ≠ 0: RGB = `pal_rgb`.
  5. Otherwise: SKY_RGB if delayed `DrawY` < `GROUND_Y`, else GROUND_RGB.
- Palette index 0 is transparent.
- **Frame edge:** `frame_clk` is registered twice. `fe` is asserted for exactly one Clk on each 0→1 transition, one Clk after the rising edge is seen.
- **Trigger edge:** `trigger` is registered. `fire` = `trigger & ~trigger_q`.
- **FSM states:** PLAY, ARMED, BLACK, WHITE, RESOLVE.
  - PLAY: `fire` and `shots_left` ≠ 0 → ARMED, and `shots_left` decrements. `fire` with `shots_left` = 0 is ignored.
  - ARMED: `fe` → BLACK. `hit_flag` clears on this transition.
  - BLACK: `fe` → WHITE.
  - WHITE: sets `hit_flag` in any Clk where stage-0 `is_duck` = 1, `DrawX == aim_x`, `DrawY == aim_y` and `blank_n` = 1. `fe` → RESOLVE.
  - RESOLVE: for 1 Clk, `hit = hit_flag` and `miss = ~hit_flag`. Then → PLAY unconditionally.
- `fire` is ignored in every state except PLAY.
- `reload` sets `shots_left = SHOTS_INIT` in any state.
- When `reload` and an accepted `fire` occur in the same Clk, `reload` wins: `shots_left` ends at `SHOTS_INIT` and the FSM still goes to ARMED.
- The state used by the colour mux is the state registered at stage 2 time. A state change takes effect on pixel output within 1 Clk. This boundary effect is allowed only at a frame edge, during vertical blanking.

## Timing
- RGB latency: `DrawX/DrawY/is_duck/duck_addr` presented at edge N → `VGA_*` valid after edge N+2, registered.
- `blank_n_out` has the same latency as RGB.
- Throughput: one pixel per Clk, with no stalls.
- Reset values:
  - `VGA_*` = 0.
  - `blank_n_out` = 0.
  - `hit` = `miss` = 0.
  - `busy` = 0.
  - State = PLAY.
  - `shots_left` = `SHOTS_INIT`.
  - `hit_flag` = 0.
  - All edge-detect and delay registers = 0.
- `rom_addr` and `pal_index` are combinational and follow their inputs. No reset applies to them.
- `Reset` asserted mid-sequence (ARMED/BLACK/WHITE/RESOLVE) → PLAY on the next edge, with no `hit`/`miss` pulse emitted.
- A `frame_clk` edge in the same Clk as `fire` in PLAY is not counted: ARMED waits for the next `fe`.
- `hit` and `miss` are mutually exclusive and never asserted outside RESOLVE.
- The fire-to-verdict sequence spans 3 frame edges.

## Test plan
- **Pipeline alignment:** drive `is_duck`=1, `blank_n`=1, DrawY=100, ROM model with 1-Clk latency returning index 5, `pal_rgb`=24'h123456 → `VGA_*` = 12/34/56 exactly 2 edges later. Index 0 instead → SKY_RGB. DrawY=400 → GROUND_RGB.
- **Blanking:** `blank_n`=0 with `is_duck`=1 → RGB 0, and `blank_n_out`=0 at the same latency.
- **Hit:** `fire` in PLAY, aim=(330,250), duck box at (320,240) → `busy`=1. After 3 `fe`: one BLACK frame (all 0), one WHITE frame (box FFFFFF), then `hit`=1 for exactly 1 Clk, `shots_left` 3→2.
- **Miss and ammo exhaustion:**
  - aim=(10,10), outside the duck box → `miss` pulse after the sequence.
  - Three fires → `shots_left`=0, and a fourth fire leaves `busy`=0.
  - `reload` → `shots_left`=3.
- **Ignored/simultaneous events:**
  - `trigger` held high → only one `fire`.
  - `fire` while in BLACK → ignored.
  - `reload` in the same Clk as an accepted `fire` → `shots_left`=3 and state ARMED.
- **Reset mid-sequence:** assert `Reset` in WHITE → next edge state PLAY, RGB 0, `shots_left`=3, and no `hit`/`miss` pulse ever emitted for the aborted shot.
